// File: rtl/bm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bm_mem_pkg
// Description : Shared types and width defaults for the bitmatrix memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bm_mem_pkg;

    localparam int c_BM_COL_W      = 64;
    localparam int c_BM_MEM_ADDR_W = 8;

    typedef enum logic {
        OWN_ENG  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/bm_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : bm_mem_arb_if
// Description : Engine, host and memory-macro signals of the bitmatrix arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bm_mem_arb_if
    import bm_mem_pkg::*;
#(
    parameter int BM_COL_W      = c_BM_COL_W,
    parameter int BM_MEM_ADDR_W = c_BM_MEM_ADDR_W
);

    logic                     eng_busy;
    logic                     bm_cntl_bm_mem_rd_rq;
    logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr;
    logic                     bm_cntl_gnt;
    logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data;
    logic                     bm_mem_bm_cntl_rd_data_val;
    logic                     host_rq;
    logic                     host_we;
    logic [BM_MEM_ADDR_W-1:0] host_addr;
    logic [BM_COL_W-1:0]      host_wr_data;
    logic                     host_gnt;
    logic [BM_COL_W-1:0]      host_rd_data;
    logic                     host_rd_data_val;
    logic                     mem_en;
    logic                     mem_we;
    logic [BM_MEM_ADDR_W-1:0] mem_addr;
    logic [BM_COL_W-1:0]      mem_wr_data;
    logic [BM_COL_W-1:0]      mem_rd_data;

    // Arbiter side
    modport slave (
        input  eng_busy, bm_cntl_bm_mem_rd_rq, bm_cntl_bm_mem_rd_addr,
        input  host_rq, host_we, host_addr, host_wr_data, mem_rd_data,
        output bm_cntl_gnt, bm_mem_bm_cntl_rd_data, bm_mem_bm_cntl_rd_data_val,
        output host_gnt, host_rd_data, host_rd_data_val,
        output mem_en, mem_we, mem_addr, mem_wr_data
    );

    // Requester and memory side
    modport master (
        output eng_busy, bm_cntl_bm_mem_rd_rq, bm_cntl_bm_mem_rd_addr,
        output host_rq, host_we, host_addr, host_wr_data, mem_rd_data,
        input  bm_cntl_gnt, bm_mem_bm_cntl_rd_data, bm_mem_bm_cntl_rd_data_val,
        input  host_gnt, host_rd_data, host_rd_data_val,
        input  mem_en, mem_we, mem_addr, mem_wr_data
    );

endinterface
`default_nettype wire

// File: rtl/bm_mem_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bm_mem_rd_tag_pipe
// Description : RD_LAT-deep {valid, owner} shift register with return demux.
// Revision    : 1.0 - initial release
// ============================================================================
module bm_mem_rd_tag_pipe
    import bm_mem_pkg::*;
#(
    parameter int BM_COL_W = c_BM_COL_W,
    parameter int RD_LAT   = 2
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire rd_tag_t             i_tag,
    input  wire logic [BM_COL_W-1:0] i_mem_rd_data,
    output logic                     o_eng_val,
    output logic [BM_COL_W-1:0]      o_eng_data,
    output logic                     o_host_val,
    output logic [BM_COL_W-1:0]      o_host_data
);

    rd_tag_t               r_tags [RD_LAT];
    logic [BM_COL_W-1:0]   r_eng_data;
    logic [BM_COL_W-1:0]   r_host_data;
    logic                  w_eng_val;
    logic                  w_host_val;

    // i_tag is taken from the registered command, so the last stage lines up
    // with the memory's data exactly RD_LAT cycles after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            r_tags[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    always_comb begin
        w_eng_val  = 1'b0;
        w_host_val = 1'b0;
        if (r_tags[RD_LAT-1].valid) begin
            w_eng_val  = (r_tags[RD_LAT-1].owner == OWN_ENG);
            w_host_val = (r_tags[RD_LAT-1].owner == OWN_HOST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eng_data  <= '0;
            r_host_data <= '0;
        end else begin
            if (w_eng_val) begin
                r_eng_data <= i_mem_rd_data;
            end
            if (w_host_val) begin
                r_host_data <= i_mem_rd_data;
            end
        end
    end

    assign o_eng_val   = w_eng_val;
    assign o_host_val  = w_host_val;
    assign o_eng_data  = w_eng_val  ? i_mem_rd_data : r_eng_data;
    assign o_host_data = w_host_val ? i_mem_rd_data : r_host_data;

endmodule
`default_nettype wire

// File: rtl/bm_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : bm_mem_arb
// Description : Engine/host arbiter and read sequencer for the bitmatrix memory.
// Revision    : 1.0 - initial release
// ============================================================================
module bm_mem_arb
    import bm_mem_pkg::*;
#(
    parameter int BM_COL_W      = c_BM_COL_W,
    parameter int BM_MEM_ADDR_W = c_BM_MEM_ADDR_W,
    parameter int RD_LAT        = 2,
    parameter int STARVE_LIM    = 4
) (
    input wire logic    clk,
    input wire logic    rst,
    bm_mem_arb_if.slave bus
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIM + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIM);

    logic                     w_eng_elig;
    logic                     w_host_elig;
    logic                     w_host_win;
    logic                     w_eng_win;
    logic [c_STARVE_W-1:0]    r_starve_cnt;
    logic                     r_eng_gnt;
    logic                     r_host_gnt;
    logic                     r_mem_en;
    logic                     r_mem_we;
    logic [BM_MEM_ADDR_W-1:0] r_mem_addr;
    logic [BM_COL_W-1:0]      r_mem_wr_data;
    rd_tag_t                  w_issue_tag;

    // Host writes sit out while the engine calculates; reads always compete.
    always_comb begin
        w_eng_elig  = bus.bm_cntl_bm_mem_rd_rq;
        w_host_elig = bus.host_rq & (~bus.host_we | ~bus.eng_busy);
        w_host_win  = w_host_elig & (~w_eng_elig | (r_starve_cnt == c_STARVE_MAX));
        w_eng_win   = w_eng_elig & ~w_host_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eng_gnt     <= 1'b0;
            r_host_gnt    <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_starve_cnt  <= '0;
        end else begin
            r_eng_gnt  <= w_eng_win;
            r_host_gnt <= w_host_win;
            r_mem_en   <= w_eng_win | w_host_win;
            r_mem_we   <= w_host_win & bus.host_we;
            if (w_host_win) begin
                r_mem_addr <= bus.host_addr;
            end else if (w_eng_win) begin
                r_mem_addr <= bus.bm_cntl_bm_mem_rd_addr;
            end
            if (w_host_win & bus.host_we) begin
                r_mem_wr_data <= bus.host_wr_data;
            end
            if (w_host_win) begin
                r_starve_cnt <= '0;
            end else if (w_host_elig && (r_starve_cnt != c_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_issue_tag.valid = r_mem_en & ~r_mem_we;
        w_issue_tag.owner = r_host_gnt ? OWN_HOST : OWN_ENG;
    end

    bm_mem_rd_tag_pipe #(
        .BM_COL_W (BM_COL_W),
        .RD_LAT   (RD_LAT)
    ) u_rd_tag_pipe (
        .clk           (clk),
        .rst           (rst),
        .i_tag         (w_issue_tag),
        .i_mem_rd_data (bus.mem_rd_data),
        .o_eng_val     (bus.bm_mem_bm_cntl_rd_data_val),
        .o_eng_data    (bus.bm_mem_bm_cntl_rd_data),
        .o_host_val    (bus.host_rd_data_val),
        .o_host_data   (bus.host_rd_data)
    );

    assign bus.bm_cntl_gnt = r_eng_gnt;
    assign bus.host_gnt    = r_host_gnt;
    assign bus.mem_en      = r_mem_en;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_data = r_mem_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_bm_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bm_mem_arb
// Description : Directed self-checking bench for bm_mem_arb with a rule-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bm_mem_arb;

    localparam int RD_LAT     = 2;
    localparam int STARVE_LIM = 4;

    typedef struct {
        bit          own;
        int          due;
        logic [63:0] data;
    } ret_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    bm_mem_arb_if #(.BM_COL_W(64), .BM_MEM_ADDR_W(8)) bif ();

    bm_mem_arb #(
        .BM_COL_W      (64),
        .BM_MEM_ADDR_W (8),
        .RD_LAT        (RD_LAT),
        .STARVE_LIM    (STARVE_LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(input logic [7:0] a);
        return (a == 8'h05) ? 64'h0000_0000_0000_A5A5 : (64'hF00D_0000_0000_0000 | {56'd0, a});
    endfunction

    // Memory macro stand-in: write at the edge, read data RD_LAT cycles after access
    logic [63:0] mem_arr [256];
    bit          mem_vld [256];
    logic [63:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (bif.mem_en && bif.mem_we) begin
            mem_arr[bif.mem_addr] <= bif.mem_wr_data;
            mem_vld[bif.mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= (bif.mem_en && !bif.mem_we)
                      ? (mem_vld[bif.mem_addr] ? mem_arr[bif.mem_addr] : init_val(bif.mem_addr))
                      : 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bif.mem_rd_data = rd_pipe[RD_LAT-1];

    // Rule-level model state
    int          cyc = 0;
    int          starve = 0;
    logic [63:0] mmem [int];
    ret_t        q [$];
    logic        exp_bg, exp_hg, exp_en, exp_we, exp_ev, exp_hv;
    logic [7:0]  exp_addr;
    logic [63:0] exp_wd, exp_ed, exp_hd;

    function automatic logic [63:0] model_rd(input logic [7:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : init_val(a);
    endfunction

    // Predicts the outputs that appear after the coming clock edge.
    task automatic model_step();
        bit   ee, he, hw, ew;
        ret_t r;
        cyc++;
        exp_ev = 1'b0;
        exp_hv = 1'b0;
        if (rst) begin
            {exp_bg, exp_hg, exp_en, exp_we} = 4'b0;
            starve = 0;
            q.delete();
            exp_ed = '0;
            exp_hd = '0;
        end else begin
            ee = bif.bm_cntl_bm_mem_rd_rq;
            he = bif.host_rq && (!bif.host_we || !bif.eng_busy);
            hw = he && (!ee || starve == STARVE_LIM);
            ew = ee && !hw;
            if (hw) starve = 0;
            else if (he) starve = (starve < STARVE_LIM) ? starve + 1 : STARVE_LIM;
            exp_bg = ew;
            exp_hg = hw;
            exp_en = ew || hw;
            exp_we = hw && bif.host_we;
            if (hw) exp_addr = bif.host_addr;
            else if (ew) exp_addr = bif.bm_cntl_bm_mem_rd_addr;
            if (exp_we) begin
                exp_wd = bif.host_wr_data;
                mmem[int'(bif.host_addr)] = bif.host_wr_data;
            end else if (exp_en) begin
                q.push_back('{own: hw, due: cyc + RD_LAT, data: model_rd(exp_addr)});
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                if (r.own) begin exp_hv = 1'b1; exp_hd = r.data; end
                else       begin exp_ev = 1'b1; exp_ed = r.data; end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    task automatic compare();
        chk("bm_cntl_gnt", 64'(bif.bm_cntl_gnt), 64'(exp_bg));
        chk("host_gnt",    64'(bif.host_gnt),    64'(exp_hg));
        chk("mem_en",      64'(bif.mem_en),      64'(exp_en));
        chk("mem_we",      64'(bif.mem_we),      64'(exp_we));
        if (exp_en) chk("mem_addr", 64'(bif.mem_addr), 64'(exp_addr));
        if (exp_we) chk("mem_wr_data", bif.mem_wr_data, exp_wd);
        chk("eng_val",   64'(bif.bm_mem_bm_cntl_rd_data_val), 64'(exp_ev));
        chk("eng_data",  bif.bm_mem_bm_cntl_rd_data, exp_ed);
        chk("host_val",  64'(bif.host_rd_data_val), 64'(exp_hv));
        chk("host_data", bif.host_rd_data, exp_hd);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_eng(input bit rq, input logic [7:0] a);
        bif.bm_cntl_bm_mem_rd_rq   = rq;
        bif.bm_cntl_bm_mem_rd_addr = a;
    endtask

    task automatic set_host(input bit rq, input bit we, input logic [7:0] a, input logic [63:0] d);
        bif.host_rq      = rq;
        bif.host_we      = we;
        bif.host_addr    = a;
        bif.host_wr_data = d;
    endtask

    logic [14:0] pat_h, pat_e;
    bit          log_own [$];
    logic [63:0] log_dat [$];
    logic [63:0] exp4_d [4];
    bit          exp4_o [4];
    bit          any_val;

    initial begin
        rst          = 1'b1;
        bif.eng_busy = 1'b0;
        set_eng(0, 8'h00);
        set_host(0, 0, 8'h00, 64'h0);
        repeat (3) tick();
        chk("rst_mem_addr",  64'(bif.mem_addr), 64'h0);
        chk("rst_eng_data",  bif.bm_mem_bm_cntl_rd_data, 64'h0);
        chk("rst_host_data", bif.host_rd_data, 64'h0);
        rst = 1'b0;
        tick();

        // Engine-only read of 0x05
        set_eng(1, 8'h05);
        tick();
        chk("t1_gnt_addr", {62'd0, bif.bm_cntl_gnt, bif.mem_en} | (64'(bif.mem_addr) << 8), 64'h0503);
        set_eng(0, 8'h00);
        tick();
        tick();
        chk("t1_val", 64'(bif.bm_mem_bm_cntl_rd_data_val), 64'h1);
        chk("t1_data", bif.bm_mem_bm_cntl_rd_data, 64'hA5A5);
        chk("t1_host_quiet", {bif.host_rd_data, 63'd0, bif.host_gnt} == '0 ? 64'h0 : 64'h1, 64'h0);

        // Host write blocked by eng_busy, then released
        bif.eng_busy = 1'b1;
        set_host(1, 1, 8'h10, 64'h1234);
        any_val = 1'b0;
        repeat (5) begin
            tick();
            any_val |= bif.host_gnt | bif.mem_we;
        end
        chk("t2_blocked", 64'(any_val), 64'h0);
        bif.eng_busy = 1'b0;
        tick();
        chk("t2_wr_gnt", {54'd0, bif.mem_addr, bif.host_gnt, bif.mem_we}, {54'd0, 8'h10, 2'b11});
        chk("t2_wr_data", bif.mem_wr_data, 64'h1234);
        set_host(1, 0, 8'h10, 64'h0);
        tick();
        set_host(0, 0, 8'h00, 64'h0);
        tick();
        tick();
        chk("t2_readback", bif.host_rd_data_val ? bif.host_rd_data : 64'hBAD, 64'h1234);

        // Both reading continuously: E,E,E,E,H repeating
        set_eng(1, 8'h21);
        set_host(1, 0, 8'h20, 64'h0);
        for (int k = 0; k < 15; k++) begin
            tick();
            pat_h[k] = bif.host_gnt;
            pat_e[k] = bif.bm_cntl_gnt;
            if (bif.host_gnt) chk("t3_starve_zero", 64'(starve), 64'h0);
        end
        chk("t3_host_pattern", 64'(pat_h), 64'h4210);
        chk("t3_eng_pattern",  64'(pat_e), 64'h3DEF);
        set_eng(0, 8'h00);
        set_host(0, 0, 8'h00, 64'h0);
        repeat (4) tick();

        // Alternating single-cycle reads 0x01..0x04
        exp4_o = '{0, 1, 0, 1};
        exp4_d = '{64'hF00D_0000_0000_0001, 64'hF00D_0000_0000_0002,
                   64'hF00D_0000_0000_0003, 64'hF00D_0000_0000_0004};
        for (int k = 0; k < 7; k++) begin
            set_eng((k == 0) || (k == 2), 8'(k + 1));
            set_host((k == 1) || (k == 3), 0, 8'(k + 1), 64'h0);
            tick();
            if (bif.bm_mem_bm_cntl_rd_data_val) begin log_own.push_back(0); log_dat.push_back(bif.bm_mem_bm_cntl_rd_data); end
            if (bif.host_rd_data_val)           begin log_own.push_back(1); log_dat.push_back(bif.host_rd_data); end
        end
        chk("t4_count", 64'(log_own.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_own.size()) begin
                chk("t4_owner", 64'(log_own[i]), 64'(exp4_o[i]));
                chk("t4_data",  log_dat[i], exp4_d[i]);
            end
        end

        // Reset with two reads in flight
        set_eng(1, 8'h01);
        tick();
        set_eng(0, 8'h00);
        set_host(1, 0, 8'h02, 64'h0);
        tick();
        set_host(0, 0, 8'h00, 64'h0);
        rst = 1'b1;
        tick();
        chk("t5_rst_outs", {bif.host_rd_data | bif.bm_mem_bm_cntl_rd_data},  64'h0);
        chk("t5_rst_ctl", {55'd0, bif.mem_addr, bif.mem_en}, 64'h0);
        rst = 1'b0;
        any_val = 1'b0;
        repeat (4) begin
            tick();
            any_val |= bif.host_rd_data_val | bif.bm_mem_bm_cntl_rd_data_val;
        end
        chk("t5_no_val", 64'(any_val), 64'h0);
        set_eng(1, 8'h03);
        tick();
        chk("t5_post_gnt", 64'(bif.bm_cntl_gnt), 64'h1);
        set_eng(0, 8'h00);
        tick();
        tick();
        chk("t5_post_data", bif.bm_mem_bm_cntl_rd_data_val ? bif.bm_mem_bm_cntl_rd_data : 64'hBAD,
            64'hF00D_0000_0000_0003);

        // Host write and eng_busy rising together with an engine read
        bif.eng_busy = 1'b1;
        set_eng(1, 8'h05);
        set_host(1, 1, 8'h30, 64'hBEEF);
        tick();
        chk("t6_eng_first", {62'd0, bif.bm_cntl_gnt, bif.host_gnt}, 64'h2);
        set_eng(0, 8'h00);
        any_val = 1'b0;
        repeat (3) begin
            tick();
            any_val |= bif.host_gnt;
        end
        chk("t6_wait", 64'(any_val), 64'h0);
        bif.eng_busy = 1'b0;
        tick();
        chk("t6_wr", {54'd0, bif.mem_addr, bif.host_gnt, bif.mem_we}, {54'd0, 8'h30, 2'b11});
        set_host(0, 0, 8'h00, 64'h0);
        set_eng(1, 8'h30);
        tick();
        set_eng(0, 8'h00);
        tick();
        tick();
        chk("t6_readback", bif.bm_mem_bm_cntl_rd_data_val ? bif.bm_mem_bm_cntl_rd_data : 64'hBAD, 64'hBEEF);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
